// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   Receives PS/2 device-to-host frames from the raw ps2_clk/ps2_dat pins,
//   validates them and buffers the scan codes in a small circular FIFO.
//   The oldest code is presented on o_data while o_ready is high. A low
//   i_nextdata_n pops one entry per clock cycle.
//
// Build option:
//   PS2_RX_PARITY_CHECK_EN - when defined, frames that fail odd parity are
//                            dropped and set o_parity_err. When undefined,
//                            parity is ignored and o_parity_err stays 0.
//
// Parameters:
//   FIFO_DEPTH     - number of buffered scan codes (power of 2, >= 2)
//   TIMEOUT_CYCLES - i_clk cycles without a ps2 clock fall before a partial
//                    frame is abandoned
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_ps2_clk      raw PS/2 clock pin (asynchronous)
//   i_ps2_dat      raw PS/2 data pin (asynchronous)
//   i_nextdata_n   active-low pop request
//   o_data         head entry while o_ready=1, otherwise 8'h00
//   o_ready        FIFO not empty
//   o_overflow     sticky: a valid frame was dropped because the FIFO was full
//   o_parity_err   sticky: a frame was dropped for bad parity
//
// Receive states:
//   state   | meaning
//   S_IDLE  | waiting for a start bit (data 0 on a ps2 clock fall)
//   S_SHIFT | collecting data, parity and stop bits; timeout armed
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    input  logic       i_nextdata_n,
    output logic [7:0] o_data,
    output logic       o_ready,
    output logic       o_overflow,
    output logic       o_parity_err
);

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PARITY_CHECK = 1'b1;
`else
    localparam bit PARITY_CHECK = 1'b0;
`endif

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    // Synchronisers: stage 0 is closest to the pin. Idle bus is high.
    logic [2:0] r_clk_sync;
    logic [2:0] r_dat_sync;
    logic       w_edge;
    logic       w_bit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 3'b111;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[1:0], i_ps2_dat};
        end
    end

    assign w_edge = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit  = r_dat_sync[2];

    // Receive FSM. r_shift collects data bits then parity, LSB first, so
    // after the 10th edge r_shift[7:0] is the byte and r_shift[8] the parity.
    state_t          r_state,   w_state_nxt;
    logic [3:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic [8:0]      r_shift,   w_shift_nxt;
    logic [TO_W-1:0] r_to_cnt,  w_to_cnt_nxt;
    logic            w_frame_push;
    logic            w_frame_perr;
    logic            w_parity_ok;

    assign w_parity_ok = ^r_shift;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 9'd0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_to_cnt_nxt  = r_to_cnt;
        w_frame_push  = 1'b0;
        w_frame_perr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bit_cnt_nxt = 4'd0;
                w_to_cnt_nxt  = '0;
                // A 1 on an edge while idle is a framing error: ignored.
                if (w_edge && !w_bit) begin
                    w_state_nxt   = S_SHIFT;
                    w_bit_cnt_nxt = 4'd1;
                end
            end
            S_SHIFT: begin
                if (w_edge) begin
                    w_to_cnt_nxt = '0;
                    if (r_bit_cnt == 4'd10) begin
                        // 11th edge: w_bit is the stop bit.
                        w_state_nxt   = S_IDLE;
                        w_bit_cnt_nxt = 4'd0;
                        if (w_bit) begin
                            if (w_parity_ok || !PARITY_CHECK) begin
                                w_frame_push = 1'b1;
                            end else begin
                                w_frame_perr = 1'b1;
                            end
                        end
                    end else begin
                        w_shift_nxt   = {w_bit, r_shift[8:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end else if (r_to_cnt == TO_MAX) begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = 4'd0;
                    w_to_cnt_nxt  = '0;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_ONE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_cnt_nxt = 4'd0;
                w_to_cnt_nxt  = '0;
            end
        endcase
    end

    // FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_parity_err;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf_set;

    assign o_ready = (r_count != '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_pop   = ~i_nextdata_n & o_ready;
    // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
    assign w_push    = w_frame_push & (~w_full | w_pop);
    assign w_ovf_set = w_frame_push & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_shift[7:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_frame_perr) begin
                r_parity_err <= 1'b1;
            end
        end
    end

    assign o_data       = o_ready ? r_mem[r_rd_ptr] : 8'h00;
    assign o_overflow   = r_overflow;
    assign o_parity_err = r_parity_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Testbench for ps2_rx_fifo: directed scenarios plus randomized traffic
// checked against a queue-based model of the receiver.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TO    = 200;
    localparam int H     = 10;   // ps2 clock half period in clk cycles

`ifdef PS2_RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       parity_err;

    int n_cmp = 0;
    int n_mis = 0;

    // reference model
    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_perr;

    ps2_rx_fifo #(
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_dat   (ps2_dat),
        .i_nextdata_n(nextdata_n),
        .o_data      (data),
        .o_ready     (ready),
        .o_overflow  (overflow),
        .o_parity_err(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par,
                                             input bit bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    // Frame-level model: what a correctly received frame does to the buffer.
    function automatic void model_frame(input logic [7:0] d, input bit bad_par,
                                        input bit bad_stop);
        if (bad_stop) return;
        if (bad_par && PCHK) begin
            m_perr = 1'b1;
            return;
        end
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(d);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        nextdata_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_perr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Sends the first n bits of frame f. With pop_at_push, nextdata_n is
    // pulsed low in the cycle the DUT detects the last edge.
    task automatic send_bits(input logic [10:0] f, input int n, input bit pop_at_push);
        for (int i = 0; i < n; i++) begin
            ps2_dat = f[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            if (pop_at_push && i == n - 1) begin
                repeat (2) @(negedge clk);
                nextdata_n = 1'b0;
                @(negedge clk);
                nextdata_n = 1'b1;
                repeat (H - 3) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        send_bits(mk_frame(d, bad_par, bad_stop), 11, 1'b0);
        model_frame(d, bad_par, bad_stop);
    endtask

    task automatic pop1();
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({data, ready, overflow, parity_err} !== 11'h000) begin
            n_mis++;
            $display("FAIL reset_outputs: got data=%h rdy=%b ovf=%b perr=%b want all 0",
                     data, ready, overflow, parity_err);
        end
    endtask

    task automatic test_single();
        logic [10:0] f;
        int rise_at;
        do_reset();
        f = mk_frame(8'h1C, 1'b0, 1'b0);
        send_bits(f, 10, 1'b0);
        ps2_dat = f[10];
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        rise_at = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ready === 1'b1 && rise_at < 0) rise_at = c;
        end
        ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
        // fall sampled at posedge 1, stage 1 at posedge 2, push at posedge 3
        n_cmp++;
        if (rise_at != 3) begin
            n_mis++;
            $display("FAIL single_latency: ready rose at negedge %0d want 3", rise_at);
        end
        n_cmp++;
        if (data !== 8'h1C) begin
            n_mis++;
            $display("FAIL single_data: got %h want 1c", data);
        end
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        n_cmp++;
        if (ready !== 1'b0 || data !== 8'h00) begin
            n_mis++;
            $display("FAIL single_pop: got rdy=%b data=%h want 0/00", ready, data);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_cmp++;
        if (data !== 8'hF0) begin
            n_mis++;
            $display("FAIL b2b_head: got %h want f0", data);
        end
        pop1();
        n_cmp++;
        if (data !== 8'h1C) begin
            n_mis++;
            $display("FAIL b2b_second: got %h want 1c", data);
        end
        pop1();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_mis++;
            $display("FAIL b2b_empty: got rdy=%b want 0", ready);
        end
        // held-low nextdata_n pops once per cycle
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        nextdata_n = 1'b0;
        repeat (2) @(negedge clk);
        nextdata_n = 1'b1;
        n_cmp++;
        if (ready !== 1'b1 || data !== 8'h33) begin
            n_mis++;
            $display("FAIL hold_pop: got rdy=%b data=%h want 1/33", ready, data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_mis++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (ready !== 1'b1 || data !== 8'(i)) begin
                n_mis++;
                $display("FAIL ovf_pop%0d: got rdy=%b data=%h want 1/%h", i, ready, data, 8'(i));
            end
            pop1();
        end
        n_cmp++;
        if (ready !== 1'b0 || overflow !== 1'b1) begin
            n_mis++;
            $display("FAIL ovf_drained: got rdy=%b ovf=%b want 0/1", ready, overflow);
        end
    endtask

    task automatic test_push_pop_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0);
        send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 11, 1'b1);
        void'(q.pop_front());
        q.push_back(8'h5A);
        n_cmp++;
        if (overflow !== 1'b0 || data !== 8'h41) begin
            n_mis++;
            $display("FAIL full_pushpop: got ovf=%b data=%h want 0/41", overflow, data);
        end
        for (int i = 0; i < DEPTH - 1; i++) pop1();
        n_cmp++;
        if (ready !== 1'b1 || data !== 8'h5A) begin
            n_mis++;
            $display("FAIL full_pushpop_tail: got rdy=%b data=%h want 1/5a", ready, data);
        end
    endtask

    task automatic test_parity();
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b0);
        n_cmp++;
        if (ready !== (q.size() != 0) || parity_err !== m_perr ||
            data !== (q.size() != 0 ? q[0] : 8'h00)) begin
            n_mis++;
            $display("FAIL parity: got rdy=%b data=%h perr=%b want %b/%h/%b", ready, data,
                     parity_err, q.size() != 0, (q.size() != 0 ? q[0] : 8'h00), m_perr);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_bits(mk_frame(8'h77, 1'b0, 1'b0), 5, 1'b0);
        repeat (TO + 10) @(negedge clk);
        send_frame(8'h2A, 1'b0, 1'b0);
        n_cmp++;
        if (ready !== 1'b1 || data !== 8'h2A || overflow !== 1'b0 || parity_err !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_frame: got rdy=%b data=%h ovf=%b perr=%b want 1/2a/0/0",
                     ready, data, overflow, parity_err);
        end
        pop1();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_single: got rdy=%b want 0", ready);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_frame(8'hA1, 1'b0, 1'b0);
        send_frame(8'hB2, 1'b0, 1'b0);
        send_bits(mk_frame(8'hC3, 1'b0, 1'b0), 6, 1'b0);
        do_reset();
        n_cmp++;
        if ({data, ready, overflow, parity_err} !== 11'h000) begin
            n_mis++;
            $display("FAIL midreset_outputs: got data=%h rdy=%b ovf=%b perr=%b want 0",
                     data, ready, overflow, parity_err);
        end
        send_frame(8'h3B, 1'b0, 1'b0);
        n_cmp++;
        if (ready !== 1'b1 || data !== 8'h3B) begin
            n_mis++;
            $display("FAIL midreset_frame: got rdy=%b data=%h want 1/3b", ready, data);
        end
        pop1();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_mis++;
            $display("FAIL midreset_single: got rdy=%b want 0", ready);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit bp, bs;
        int np;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                // stray edge with data high while idle: nothing recorded
                send_bits(11'h7FF, 1, 1'b0);
            end
            d  = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 7) == 0);
            send_frame(d, bp, bs);
            n_cmp++;
            if (ready !== (q.size() != 0) || data !== (q.size() != 0 ? q[0] : 8'h00) ||
                overflow !== m_ovf || parity_err !== m_perr) begin
                n_mis++;
                $display("FAIL random_%0d: got rdy=%b data=%h ovf=%b perr=%b want %b/%h/%b/%b",
                         it, ready, data, overflow, parity_err, q.size() != 0,
                         (q.size() != 0 ? q[0] : 8'h00), m_ovf, m_perr);
            end
            np = $urandom_range(0, 2);
            for (int k = 0; k < np; k++) begin
                pop1();
                n_cmp++;
                if (ready !== (q.size() != 0) || data !== (q.size() != 0 ? q[0] : 8'h00)) begin
                    n_mis++;
                    $display("FAIL random_pop_%0d: got rdy=%b data=%h want %b/%h", it, ready,
                             data, q.size() != 0, (q.size() != 0 ? q[0] : 8'h00));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_parity();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Upstream stage of the keyboard path: deserialises PS/2 device-to-host frames from the raw `ps2_clk`/`ps2_dat` pins, validates them, and buffers scan codes in a small FIFO. It presents the oldest code on `data` with a `ready` flag and pops on the active-low `nextdata_n` strobe. Its outputs feed the scan-code-to-ASCII mapper directly, and `data` reads 8'h00 whenever nothing is buffered.

## Interface
- `FIFO_DEPTH`, 8: number of buffered scan codes; must be a power of 2, at least 2.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is aborted (1 ms at 50 MHz).
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_dat` input 1: raw PS/2 data pin, asynchronous to `clk`.
- `nextdata_n` input 1: active-low pop request, sampled on `clk`.
- `data` output 8: head FIFO entry when `ready`=1; 8'h00 when empty.
- `ready` output 1: FIFO non-empty.
- `overflow` output 1: sticky; a valid frame was dropped because the FIFO was full.
- `parity_err` output 1: sticky; a frame was dropped for bad parity.

## Operation
- Synchroniser: `ps2_clk` and `ps2_dat` each pass through 3 flip-flops. A falling edge is detected when synced clock stages [2:1] = 2'b10. The bit is taken from synced `ps2_dat` stage 2 in that same cycle.
- Frame format, LSB first: start bit (0), 8 data bits, odd parity, stop bit (1). That is 11 falling edges per frame.
- Receive FSM:
  - IDLE: bit count 0. On an edge with bit = 0, go to SHIFT with count 1. On an edge with bit = 1, stay in IDLE (framing error, nothing recorded).
  - SHIFT: each edge shifts one bit in and increments the count. On the 11th edge, evaluate the frame and return to IDLE.
  - Timeout: a timeout counter is cleared on every edge and counts while in SHIFT. When it reaches `TIMEOUT_CYCLES`, return to IDLE and discard the partial frame. No flag is set.
- Evaluation on the 11th edge:
  - Stop bit 0: discard silently.
  - Parity error: handled per Configuration.
  - Otherwise: push the data byte.
- FIFO: circular buffer with read and write pointers of log2(`FIFO_DEPTH`) bits each, plus a count of log2(`FIFO_DEPTH`)+1 bits. Pointers wrap modulo `FIFO_DEPTH`.
- Pop: occurs at a rising edge when `nextdata_n`=0 and `ready`=1. `nextdata_n`=0 while empty is ignored. A held-low `nextdata_n` pops once per cycle.
- Push when full: the frame is dropped, `overflow` is set, and FIFO contents are unchanged.
- Push and pop in the same cycle, FIFO non-empty: both take effect and the count is unchanged. This holds even when full, because the pop frees the slot; no overflow is flagged.
- Push into an empty FIFO: no same-cycle pop is possible, since `ready` is still 0.
- Reset values:
  - `data` = 8'h00, `ready` = 0, `overflow` = 0, `parity_err` = 0.
  - FSM in IDLE; pointers, count and timeout counter all 0.
  - Synchroniser flip-flops = 1 (idle-high bus).
- Reset mid-frame discards the partial frame. FIFO contents are lost.
- `overflow` and `parity_err` clear only on `rst`.

## Timing
- Pin to edge-detect latency: 3 `clk` cycles after a `ps2_clk` fall.
- Push is written at the rising edge ending the 11th-edge-detect cycle. `ready` and `data` are valid from the next cycle.
- `ready` and `data` are combinational from registered FIFO state: no read latency after a pointer update.
- After a pop edge, `data` shows the next entry, or 8'h00 with `ready`=0, in the following cycle.
- `clk` must be at least 20x the PS/2 clock (10–16.7 kHz); the minimum PS/2 low/high phase (30 µs) is then many `clk` cycles.

## Configuration
- `PS2_RX_PARITY_CHECK_EN`
  - Defined: frames failing odd parity are not pushed and set `parity_err`.
  - Undefined: the parity bit is shifted in but ignored, and `parity_err` is tied to 0.

## Test plan
- Send frame 8'h1C with correct parity and stop bit -> `ready` rises 1 cycle after the 11th detected edge, `data`=8'h1C; pulse `nextdata_n` low 1 cycle -> `ready`=0, `data`=8'h00.
- Send 8'hF0 then 8'h1C with no pops -> `data`=8'hF0; after 1 pop `data`=8'h1C; after a 2nd pop `ready`=0.
- Send 9 frames 8'h01..8'h09 with `FIFO_DEPTH`=8 and no pops -> `overflow`=1; popping 8 times returns 8'h01..8'h08, then `ready`=0.
- Send 8'h1C with the parity bit inverted -> with the macro: no push, `parity_err`=1; without: push 8'h1C, `parity_err`=0.
- Send 5 bits, stall `ps2_clk` high for `TIMEOUT_CYCLES`+10 cycles, then send a full frame 8'h2A -> only 8'h2A is buffered, and no flag is set.
- Assert `rst` after 6 bits of a frame with 2 entries buffered -> all outputs at reset values; the next full frame 8'h3B is received cleanly.
